config_loader: RTL and testbench
================================

# config_loader

Drives the serial configuration chain of one or more config tiles from a word-wide stream. It accepts configuration words over a valid/ready handshake and serializes them MSB-first onto the chain's data input, asserting shift-enable only on cycles that carry a valid bit. After exactly CHAIN_LEN bits have been shifted, it pulses the chain's set strobe and reports completion. It sits between the bitstream source (host interface or on-chip ROM) and the hard-configuration port of the tile chain.

## Interface

Parameters:
- WORD_W, 8, width of each input configuration word.
- CHAIN_LEN, 14, total number of bits in the downstream chain; must be ≥ 1.
- CNT_W, $clog2(CHAIN_LEN+1), width of the bit counter; derived, do not override.

Ports:
- clk  in  1  single clock for all state.
- rst  in  1  reset, asynchronous assert, active-low (rst=0 resets).
- start  in  1  one-cycle request to begin a load; honoured only in IDLE.
- in_data  in  WORD_W  configuration word, MSB shifted first.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader will accept in_data this cycle.
- cfg_data  out  1  serial bit to the chain (drives the chain's hard shift input).
- cfg_shift_en  out  1  chain shifts on this edge; high only when cfg_data is a real bit.
- cfg_set  out  1  one-cycle strobe committing the chain contents (drives the hard set).
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after cfg_set.

## Operation

- States: IDLE, LOAD, SET, DONE.
- IDLE: in_ready=0, all chain outputs 0. start=1 → LOAD, bits_left←CHAIN_LEN, buffer empty.
- LOAD: one-word buffer (buf, idx). While the buffer holds a bit, cfg_data=buf[idx], cfg_shift_en=1, idx decrements, bits_left decrements each cycle.
- in_ready=1 in LOAD when (buffer empty, or the last bit of buf is being shifted this cycle) and bits_left after this cycle's shift > 0. This gives gapless back-to-back streaming.
- A handshake (in_valid & in_ready) loads buf←in_data, idx←WORD_W-1.
- Buffer empty and no word arriving: stall. cfg_shift_en=0 and cfg_data=0; chain holds. Stalls are unbounded.
- When bits_left reaches 0, the cycle after the final shift is SET. Unused low-order bits of the final word (WORD_W·ceil(CHAIN_LEN/WORD_W) − CHAIN_LEN of them) are discarded. No further word is accepted.
- SET: cfg_set=1, cfg_shift_en=0, one cycle → DONE.
- DONE: done=1 for one cycle, busy drops → IDLE.
- start outside IDLE is ignored. in_valid outside LOAD is ignored; the word is not consumed.
- Reset at any point returns to IDLE, clears the buffer and counters, and deasserts all outputs. The chain is left partially shifted; a new start reloads it fully.

## Timing

- Reset values: in_ready=0, cfg_data=0, cfg_shift_en=0, cfg_set=0, busy=0, done=0.
- All outputs are registered or decoded from registered state only. The only combinational input→output path is in_valid→(none); in_ready does not depend on in_valid.
- start sampled at edge t → busy=1 and in_ready=1 from cycle t+1.
- Word accepted at edge t → its MSB appears on cfg_data with cfg_shift_en=1 during cycle t+1. Bit k (from MSB) appears in cycle t+1+k.
- Last chain bit shifted in cycle L → cfg_set=1 in cycle L+1 → done=1 in cycle L+2 → IDLE (busy=0) from L+3.
- Minimum load with no stalls, start at edge 0: first word accepted at edge 1, bits in cycles 2..CHAIN_LEN+1, cfg_set at CHAIN_LEN+2, done at CHAIN_LEN+3.

## Test plan

- Basic: CHAIN_LEN=14, WORD_W=8, in_valid always high with words 0xA5, 0x3C. Required: 14 consecutive cycles with cfg_shift_en=1 and cfg_data = 1,0,1,0,0,1,0,1,0,0,1,1,1,1. Then cfg_set for 1 cycle, then done for 1 cycle. Exactly 2 handshakes occur; a third offered word is not accepted.
- Stall: same words, with in_valid dropped for 3 cycles after the first word. Required: cfg_shift_en=0 for exactly 3 cycles between bit 7 and bit 8. The bit sequence is unchanged, and cfg_set comes 3 cycles later than in the basic case.
- Exact fit: CHAIN_LEN=16, words 0xFF, 0x00. Required: 16 shifts (8 ones, then 8 zeros), with no gap at the word boundary and in_ready low after the second handshake.
- Ignored start: pulse start during LOAD and during SET. Required: no state change, a single done pulse, and bit count still 14.
- Reset mid-load: assert rst=0 after 5 bits. Required: all outputs 0 immediately (async). After release, a new start with 0xA5, 0x3C yields the full 14-bit sequence from the first bit.
- Reset/idle behaviour: in_valid high in IDLE with no start. Required: in_ready=0, no shifts, and busy=0 throughout.

Source files
------------

// File: rtl/config_loader.sv
// config_loader: serializes a word stream MSB-first into a tile configuration
// chain, strobes the chain's set input once CHAIN_LEN bits are in, then reports done.
module config_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 14,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              cfg_data,
  output logic              cfg_shift_en,
  output logic              cfg_set,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(WORD_W - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, LOAD, SET, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WORD_W-1:0] word_buf;
  logic [IDX_W-1:0]  idx;
  logic              buf_vld;
  logic [CNT_W-1:0]  bits_left;

  logic shift_now;
  logic last_of_word;
  logic last_of_chain;
  logic accept;

  always_comb begin
    shift_now     = (state == LOAD) && buf_vld;
    last_of_word  = shift_now && (idx == '0);
    last_of_chain = shift_now && (bits_left == CNT_ONE);
  end

  assign accept = in_ready && in_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Ready is offered while the last buffered bit is still shifting so that
  // consecutive words stream without a bubble; it never looks at in_valid.
  always_comb begin
    state_nxt    = state;
    in_ready     = 1'b0;
    cfg_data     = 1'b0;
    cfg_shift_en = 1'b0;
    cfg_set      = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        in_ready     = (!buf_vld || (idx == '0)) && !last_of_chain;
        cfg_shift_en = buf_vld;
        cfg_data     = buf_vld && word_buf[idx];
        if (last_of_chain) begin
          state_nxt = SET;
        end
      end
      SET: begin
        cfg_set   = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Remaining low-order bits of the final word are dropped on the last chain bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bits_left <= '0;
      buf_vld   <= 1'b0;
      idx       <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        bits_left <= CNT_FULL;
      end else if (shift_now) begin
        bits_left <= bits_left - CNT_ONE;
      end

      if (accept) begin
        buf_vld <= 1'b1;
        idx     <= IDX_TOP;
      end else if (last_of_chain || last_of_word) begin
        buf_vld <= 1'b0;
      end else if (shift_now) begin
        idx <= idx - IDX_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      word_buf <= in_data;
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// Self-checking bench for config_loader: table vectors, hand-written reset/idle
// sequences and randomized loads checked against a bit-stream reference model.
module tb_config_loader;

  localparam int WORD_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic             start_v    [2];
  logic [WORD_W-1:0] in_data_v [2];
  logic             in_valid_v [2];
  logic             in_ready_v [2];
  logic             cfg_data_v [2];
  logic             cfg_shift_en_v [2];
  logic             cfg_set_v  [2];
  logic             busy_v     [2];
  logic             done_v     [2];

  always #5 clk = ~clk;

  config_loader #(.WORD_W(WORD_W), .CHAIN_LEN(14)) dut14 (
    .clk(clk), .rst(rst), .start(start_v[0]), .in_data(in_data_v[0]),
    .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]), .cfg_data(cfg_data_v[0]),
    .cfg_shift_en(cfg_shift_en_v[0]), .cfg_set(cfg_set_v[0]), .busy(busy_v[0]),
    .done(done_v[0])
  );

  config_loader #(.WORD_W(WORD_W), .CHAIN_LEN(16)) dut16 (
    .clk(clk), .rst(rst), .start(start_v[1]), .in_data(in_data_v[1]),
    .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]), .cfg_data(cfg_data_v[1]),
    .cfg_shift_en(cfg_shift_en_v[1]), .cfg_set(cfg_set_v[1]), .busy(busy_v[1]),
    .done(done_v[1])
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int cl_of(input int s);
    return (s != 0) ? 16 : 14;
  endfunction

  // Per-transaction observations
  logic [WORD_W-1:0] src_q[$];
  logic [WORD_W-1:0] acc_q[$];
  bit bits_q[$];
  int shift_cyc_q[$];
  int hs_cnt, set_cyc, done_cyc, n_set, n_done, busy_bad, cdata_bad;

  task automatic run_txn(input int s, input int stall_len, input int rnd_pct, input bit ign_start);
    int withheld;
    bit fin;
    bit v;
    bit stall_act;
    withheld = 0; fin = 0;
    hs_cnt = 0; set_cyc = -1; done_cyc = -1; n_set = 0; n_done = 0;
    busy_bad = 0; cdata_bad = 0;
    acc_q.delete(); bits_q.delete(); shift_cyc_q.delete();
    @(posedge clk); #1;
    start_v[s] = 1'b1;
    in_valid_v[s] = 1'b0;
    @(posedge clk); #1;
    start_v[s] = 1'b0;
    for (int cyc = 1; cyc <= 200 && !fin; cyc++) begin
      start_v[s] = ign_start && (cyc == 5 || cyc == 16);
      stall_act = (stall_len > 0) && (hs_cnt == 1) && (withheld < stall_len);
      v = (src_q.size() > 0) && !stall_act;
      if (rnd_pct > 0 && $urandom_range(99) < rnd_pct) v = 1'b0;
      in_valid_v[s] = v;
      in_data_v[s]  = (src_q.size() > 0 && v) ? src_q[0] : WORD_W'($urandom);
      @(negedge clk);
      if (in_valid_v[s] && in_ready_v[s]) begin
        acc_q.push_back(in_data_v[s]);
        if (src_q.size() > 0) void'(src_q.pop_front());
        hs_cnt++;
      end
      if (stall_act && in_ready_v[s]) withheld++;
      if (cfg_shift_en_v[s]) begin
        bits_q.push_back(cfg_data_v[s]);
        shift_cyc_q.push_back(cyc);
      end else if (cfg_data_v[s] !== 1'b0) begin
        cdata_bad++;
      end
      if (cfg_set_v[s]) begin n_set++; set_cyc = cyc; end
      if (done_v[s]) begin n_done++; done_cyc = cyc; end
      if (busy_v[s] !== ((done_cyc < 0) || (cyc <= done_cyc))) busy_bad++;
      if (done_cyc >= 0 && cyc >= done_cyc + 3) fin = 1'b1;
      if (!fin) begin
        @(posedge clk); #1;
      end
    end
    chk("timeout_done_seen", (done_cyc >= 0), 1);
    in_valid_v[s] = 1'b0;
    start_v[s] = 1'b0;
  endtask

  typedef struct {
    int          sel;
    logic [7:0]  w0, w1, w2;
    int          stall;
    bit          ign;
    logic [15:0] exp_bits;
    int          exp_len;
    int          exp_set;
    int          exp_hs;
    int          exp_gap;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [15:0] got;
    int gap;
    int n;
    logic [WORD_W-1:0] offered[$];
    bit exp_q[$];
    int cl;
    int mism;

    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0; in_valid_v[i] = 1'b0; in_data_v[i] = '0;
    end

    vecs[0] = '{0, 8'hA5, 8'h3C, 8'hC3, 0, 1'b0, 16'b10100101001111, 14, 16, 2, 0};
    vecs[1] = '{0, 8'hA5, 8'h3C, 8'hC3, 3, 1'b0, 16'b10100101001111, 14, 19, 2, 3};
    vecs[2] = '{1, 8'hFF, 8'h00, 8'h55, 0, 1'b0, 16'hFF00,           16, 18, 2, 0};
    vecs[3] = '{0, 8'hA5, 8'h3C, 8'hC3, 0, 1'b1, 16'b10100101001111, 14, 16, 2, 0};

    // Reset state of both instances
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++)
      chk($sformatf("reset_outputs%0d", i),
          {in_ready_v[i], cfg_data_v[i], cfg_shift_en_v[i], cfg_set_v[i], busy_v[i], done_v[i]}, 0);
    @(negedge clk);
    rst = 1'b1;

    // Idle: in_valid held high without start
    in_valid_v[0] = 1'b1;
    in_data_v[0]  = 8'hA5;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("idle_c%0d", c), {in_ready_v[0], cfg_shift_en_v[0], busy_v[0], done_v[0]}, 0);
    end
    in_valid_v[0] = 1'b0;

    // Table vectors
    for (int t = 0; t < 4; t++) begin
      src_q = {vecs[t].w0, vecs[t].w1, vecs[t].w2};
      run_txn(vecs[t].sel, vecs[t].stall, 0, vecs[t].ign);
      got = '0;
      foreach (bits_q[i]) got = {got[14:0], bits_q[i]};
      gap = (shift_cyc_q.size() >= 9) ? (shift_cyc_q[8] - shift_cyc_q[7] - 1) : -99;
      chk($sformatf("v%0d_bits", t), got, vecs[t].exp_bits);
      chk($sformatf("v%0d_len", t), bits_q.size(), vecs[t].exp_len);
      chk($sformatf("v%0d_first_shift", t), (shift_cyc_q.size() > 0) ? shift_cyc_q[0] : -1, 2);
      chk($sformatf("v%0d_last_shift", t),
          (shift_cyc_q.size() > 0) ? shift_cyc_q[shift_cyc_q.size()-1] : -1, vecs[t].exp_set - 1);
      chk($sformatf("v%0d_gap", t), gap, vecs[t].exp_gap);
      chk($sformatf("v%0d_set_cyc", t), set_cyc, vecs[t].exp_set);
      chk($sformatf("v%0d_done_cyc", t), done_cyc, vecs[t].exp_set + 1);
      chk($sformatf("v%0d_n_set", t), n_set, 1);
      chk($sformatf("v%0d_n_done", t), n_done, 1);
      chk($sformatf("v%0d_handshakes", t), hs_cnt, vecs[t].exp_hs);
      chk($sformatf("v%0d_busy", t), busy_bad, 0);
      chk($sformatf("v%0d_cdata_idle", t), cdata_bad, 0);
    end

    // Reset in the middle of a load
    @(posedge clk); #1;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    in_valid_v[0] = 1'b1;
    in_data_v[0]  = 8'hA5;
    n = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (cfg_shift_en_v[0]) n++;
      @(posedge clk); #1;
    end
    chk("rst_pre_bits", n, 5);
    chk("rst_pre_busy", {busy_v[0], cfg_shift_en_v[0]}, 2'b11);
    rst = 1'b0;
    #1;
    chk("rst_async_outputs",
        {in_ready_v[0], cfg_data_v[0], cfg_shift_en_v[0], cfg_set_v[0], busy_v[0], done_v[0]}, 0);
    in_valid_v[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_held_outputs", {in_ready_v[0], cfg_shift_en_v[0], busy_v[0]}, 0);
    rst = 1'b1;
    src_q = {8'hA5, 8'h3C, 8'hC3};
    run_txn(0, 0, 0, 1'b0);
    got = '0;
    foreach (bits_q[i]) got = {got[14:0], bits_q[i]};
    chk("rst_reload_bits", got, 16'b10100101001111);
    chk("rst_reload_len", bits_q.size(), 14);
    chk("rst_reload_set", set_cyc, 16);

    // Randomized loads against the bit-stream model
    for (int r = 0; r < 24; r++) begin
      int s;
      int pct;
      s = $urandom_range(1);
      pct = $urandom_range(60);
      cl = cl_of(s);
      offered.delete();
      for (int k = 0; k < 3; k++) offered.push_back(WORD_W'($urandom));
      exp_q.delete();
      foreach (offered[k])
        for (int b = WORD_W - 1; b >= 0; b--) exp_q.push_back(offered[k][b]);
      src_q = offered;
      run_txn(s, 0, pct, 1'b0);
      mism = 0;
      for (int i = 0; i < cl; i++)
        if (i >= bits_q.size() || bits_q[i] !== exp_q[i]) mism++;
      chk($sformatf("r%0d_bits", r), mism, 0);
      chk($sformatf("r%0d_len", r), bits_q.size(), cl);
      chk($sformatf("r%0d_handshakes", r), hs_cnt, (cl + WORD_W - 1) / WORD_W);
      chk($sformatf("r%0d_set_after_last", r), set_cyc,
          (shift_cyc_q.size() > 0) ? shift_cyc_q[shift_cyc_q.size()-1] + 1 : -5);
      chk($sformatf("r%0d_done_after_set", r), done_cyc, set_cyc + 1);
      chk($sformatf("r%0d_pulses", r), {n_set[3:0], n_done[3:0]}, 8'h11);
      chk($sformatf("r%0d_busy", r), busy_bad + cdata_bad, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
